// File: rtl/instr_mem_loader.sv
// instr_mem_loader: packs the debug UART byte stream into 32-bit words and
// drives the instruction memory debug write port at addresses 0,4,8,...
// The load ends after the halt word is written or when memory is full.
// Optional feature macro: LOADER_CHECKSUM_EN adds a trailing XOR checksum
// byte after the halt word and the o_ChkErr output.
//
// state | meaning
// IDLE  | after reset, waiting for i_Start
// RECV  | collecting bytes of the current word, MSB first
// SETUP | latch write address/data, strobe low
// PULSE | write strobe high, address/data stable
// ADV   | strobe low, bump word count, decide halt/overflow/continue
// CHK   | (checksum build) waiting for the checksum byte
// DONE  | load finished, waiting for a new i_Start
module instr_mem_loader #(
  parameter int               NBITS     = 32,
  parameter int               CELDAS    = 256,
  parameter int               NBYTE     = 8,
  parameter logic [NBITS-1:0] HALT_WORD = {NBITS{1'b1}}
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_Start,
  input  logic             i_RxDone,
  input  logic [NBYTE-1:0] i_RxData,
  output logic [NBITS-1:0] o_DirecDebug,
  output logic [NBITS-1:0] o_DatoDebug,
  output logic             o_WriteDebug,
  output logic             o_Busy,
  output logic             o_Loaded,
  output logic             o_Overflow,
  output logic             o_Overrun,
  output logic [NBITS-1:0] o_WordCount
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic             o_ChkErr
`endif
);

  localparam int               NB       = NBITS / NBYTE;
  localparam int               IDX_W    = $clog2(NB);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NB - 1);
  localparam logic [NBITS-1:0] N_WORDS  = NBITS'(CELDAS / 4);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_SETUP,
    S_PULSE,
    S_ADV,
    S_DONE
`ifdef LOADER_CHECKSUM_EN
    ,
    S_CHK
`endif
  } state_t;

  state_t             state, state_nx;
  logic [IDX_W-1:0]   idx;
  logic [NBITS-1:0]   word_sr;
  logic               last_byte;
  logic               is_halt;
  logic               mem_full;
`ifdef LOADER_CHECKSUM_EN
  logic [NBYTE-1:0]   chk_xor;
`endif

  assign last_byte = i_RxDone && (idx == IDX_LAST);
  assign is_halt   = (o_DatoDebug == HALT_WORD);
  assign mem_full  = ((o_WordCount + NBITS'(1)) == N_WORDS);

  // State register
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) state <= S_IDLE;
    else          state <= state_nx;
  end

  // Next-state decode
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (i_Start) state_nx = S_RECV;
      S_RECV:  if (last_byte) state_nx = S_SETUP;
      S_SETUP: state_nx = S_PULSE;
      S_PULSE: state_nx = S_ADV;
      S_ADV: begin
        if (is_halt) begin
`ifdef LOADER_CHECKSUM_EN
          state_nx = S_CHK;
`else
          state_nx = S_DONE;
`endif
        end else if (mem_full) begin
          state_nx = S_DONE;
        end else begin
          state_nx = S_RECV;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHK:   if (i_RxDone) state_nx = S_DONE;
`endif
      S_DONE:  if (i_Start) state_nx = S_RECV;
      default: state_nx = S_IDLE;
    endcase
  end

  // State-decoded outputs: strobe only in PULSE, busy while a load is active
  always_comb begin
    o_WriteDebug = 1'b0;
    o_Busy       = 1'b0;
    case (state)
      S_RECV, S_SETUP, S_ADV: o_Busy = 1'b1;
      S_PULSE: begin
        o_Busy       = 1'b1;
        o_WriteDebug = 1'b1;
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHK:   o_Busy = 1'b1;
`endif
      default: ;
    endcase
  end

  // Word assembly, write port registers, counters and status flags
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      idx          <= '0;
      word_sr      <= '0;
      o_DirecDebug <= '0;
      o_DatoDebug  <= '0;
      o_WordCount  <= '0;
      o_Loaded     <= 1'b0;
      o_Overflow   <= 1'b0;
      o_Overrun    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      chk_xor      <= '0;
      o_ChkErr     <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (i_Start) begin
            idx         <= '0;
            word_sr     <= '0;
            o_WordCount <= '0;
            o_Loaded    <= 1'b0;
            o_Overflow  <= 1'b0;
            o_Overrun   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            chk_xor     <= '0;
            o_ChkErr    <= 1'b0;
`endif
          end
        end
        S_RECV: begin
          if (i_RxDone) begin
            word_sr <= {word_sr[NBITS-NBYTE-1:0], i_RxData};
            idx     <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
`ifdef LOADER_CHECKSUM_EN
            chk_xor <= chk_xor ^ i_RxData;
`endif
          end
        end
        S_SETUP: begin
          o_DatoDebug  <= word_sr;
          o_DirecDebug <= o_WordCount << 2;
          if (i_RxDone) o_Overrun <= 1'b1;
        end
        S_PULSE: begin
          if (i_RxDone) o_Overrun <= 1'b1;
        end
        S_ADV: begin
          o_WordCount <= o_WordCount + NBITS'(1);
          if (i_RxDone) o_Overrun <= 1'b1;
          if (is_halt) begin
`ifndef LOADER_CHECKSUM_EN
            o_Loaded <= 1'b1;
`endif
          end else if (mem_full) begin
            o_Overflow <= 1'b1;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        S_CHK: begin
          if (i_RxDone) begin
            if (i_RxData == chk_xor) o_Loaded <= 1'b1;
            else                     o_ChkErr <= 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Testbench for instr_mem_loader: directed and randomized byte streams
// checked against a timing-aware reference model of the loader.
module tb_instr_mem_loader;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_Start = 1'b0;
  logic        i_RxDone = 1'b0;
  logic [7:0]  i_RxData = 8'h00;
  logic [31:0] o_DirecDebug, o_DatoDebug, o_WordCount;
  logic        o_WriteDebug, o_Busy, o_Loaded, o_Overflow, o_Overrun;
`ifdef LOADER_CHECKSUM_EN
  logic        o_ChkErr;
`endif

  instr_mem_loader dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_Start      (i_Start),
    .i_RxDone     (i_RxDone),
    .i_RxData     (i_RxData),
    .o_DirecDebug (o_DirecDebug),
    .o_DatoDebug  (o_DatoDebug),
    .o_WriteDebug (o_WriteDebug),
    .o_Busy       (o_Busy),
    .o_Loaded     (o_Loaded),
    .o_Overflow   (o_Overflow),
    .o_Overrun    (o_Overrun),
    .o_WordCount  (o_WordCount)
`ifdef LOADER_CHECKSUM_EN
    ,
    .o_ChkErr     (o_ChkErr)
`endif
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  // Rising-edge index; the next edge sampled by the DUT is cyc+1
  always @(posedge i_clk) cyc <= cyc + 1;

  // Reference model: a load is a byte stream packed MSB first into words,
  // word k written at address 4k; after a word completes at edge n the
  // loader is deaf for edges n+1..n+3 (those bytes are dropped as overrun).
  logic [63:0] exp_q[$];
  logic [63:0] act_q[$];
  bit          m_loading, m_chk_wait, m_loaded, m_overflow, m_overrun, m_chkerr;
  int          m_n, m_count, m_last;
  logic [31:0] m_word;
  logic [7:0]  m_xor;

  int passed = 0;
  int total  = 0;
  int last_wr = -100;
  int strobe_viol = 0;

  // Capture every write the DUT performs and watch strobe spacing
  always @(negedge i_clk) begin
    if (i_reset && o_WriteDebug) begin
      if (cyc - last_wr < 4) strobe_viol++;
      act_q.push_back({o_DirecDebug, o_DatoDebug});
      last_wr = cyc;
    end
  end

  task automatic m_reset();
    m_loading = 0; m_chk_wait = 0; m_loaded = 0; m_overflow = 0;
    m_overrun = 0; m_chkerr = 0; m_n = 0; m_count = 0; m_last = -100;
    m_word = '0; m_xor = '0;
  endtask

  task automatic m_start(input int c);
    if (m_loading || c <= m_last + 3) return;
    m_loading = 1; m_chk_wait = 0; m_loaded = 0; m_overflow = 0;
    m_overrun = 0; m_chkerr = 0; m_n = 0; m_count = 0; m_word = '0; m_xor = '0;
  endtask

  task automatic m_byte(input logic [7:0] b, input int c);
    if (c <= m_last + 3) begin
      m_overrun = 1;
      return;
    end
    if (!m_loading) return;
    if (m_chk_wait) begin
      m_chkerr = (b != m_xor);
      m_loaded = !m_chkerr;
      m_loading = 0;
      m_chk_wait = 0;
      return;
    end
    m_xor  = m_xor ^ b;
    m_word = {m_word[23:0], b};
    m_n++;
    if (m_n == 4) begin
      m_n = 0;
      exp_q.push_back({32'(m_count * 4), m_word});
      m_count++;
      m_last = c;
      if (m_word == 32'hFFFF_FFFF) begin
`ifdef LOADER_CHECKSUM_EN
        m_chk_wait = 1;
`else
        m_loaded = 1;
        m_loading = 0;
`endif
      end else if (m_count == 64) begin
        m_overflow = 1;
        m_loading = 0;
      end
    end
  endtask

  // All drive tasks are entered at a falling edge and leave at one
  task automatic rx(input logic [7:0] b, input int idle);
    i_RxData = b; i_RxDone = 1'b1;
    m_byte(b, cyc + 1);
    @(negedge i_clk);
    i_RxDone = 1'b0;
    repeat (idle) @(negedge i_clk);
  endtask

  task automatic start();
    i_Start = 1'b1;
    m_start(cyc + 1);
    @(negedge i_clk);
    i_Start = 1'b0;
    @(negedge i_clk);
  endtask

  task automatic start_rx(input logic [7:0] b);
    i_Start = 1'b1; i_RxDone = 1'b1; i_RxData = b;
    m_byte(b, cyc + 1);
    m_start(cyc + 1);
    @(negedge i_clk);
    i_Start = 1'b0; i_RxDone = 1'b0;
    @(negedge i_clk);
  endtask

  task automatic send_word(input logic [31:0] w, input int idle);
    for (int k = 3; k >= 0; k--) rx(w[8*k +: 8], idle);
  endtask

  task automatic send_chk(input bit good);
    if (m_chk_wait) rx(good ? m_xor : (m_xor ^ 8'h5A), 3);
  endtask

  task automatic do_reset();
    i_reset = 1'b0;
    m_reset();
    last_wr = -100;
    repeat (2) @(negedge i_clk);
    i_reset = 1'b1;
    @(negedge i_clk);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    check({tag, ".loaded"},   64'(o_Loaded),    64'(m_loaded));
    check({tag, ".overflow"}, 64'(o_Overflow),  64'(m_overflow));
    check({tag, ".overrun"},  64'(o_Overrun),   64'(m_overrun));
    check({tag, ".busy"},     64'(o_Busy),      64'(m_loading));
    check({tag, ".count"},    64'(o_WordCount), 64'(m_count));
`ifdef LOADER_CHECKSUM_EN
    check({tag, ".chkerr"},   64'(o_ChkErr),    64'(m_chkerr));
`endif
    check({tag, ".nwrites"},  64'(act_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++)
      check($sformatf("%s.wr%0d", tag, i), act_q[i], exp_q[i]);
    check({tag, ".spacing"},  64'(strobe_viol), 64'd0);
    act_q.delete();
    exp_q.delete();
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".addr"},  64'(o_DirecDebug), 64'd0);
    check({tag, ".data"},  64'(o_DatoDebug),  64'd0);
    check({tag, ".we"},    64'(o_WriteDebug), 64'd0);
    check({tag, ".busy"},  64'(o_Busy),       64'd0);
    check({tag, ".count"}, 64'(o_WordCount),  64'd0);
    check({tag, ".flags"}, 64'({o_Loaded, o_Overflow, o_Overrun}), 64'd0);
  endtask

  initial begin
    m_reset();
    repeat (3) @(negedge i_clk);
    check_zero("reset");
    i_reset = 1'b1;
    @(negedge i_clk);

    // 1: basic two-word program
    start();
    check("t1.busy_start", 64'(o_Busy), 64'd1);
    send_word(32'h0022_0820, 3);
    send_word(32'hFFFF_FFFF, 3);
    send_chk(1);
    repeat (8) @(negedge i_clk);
    check("t1.count_fixed", 64'(o_WordCount), 64'd2);
    check("t1.loaded_fixed", 64'(o_Loaded), 64'd1);
    check_all("t1");

    // 2: bytes arriving during the write sequence are dropped
    do_reset();
    start();
    rx(8'hAA, 3); rx(8'hBB, 3); rx(8'hCC, 3);
    rx(8'hDD, 0); rx(8'h11, 0); rx(8'h22, 0); rx(8'h33, 3);
    send_word(32'h4455_6677, 3);
    send_word(32'hFFFF_FFFF, 3);
    send_chk(1);
    repeat (8) @(negedge i_clk);
    check("t2.overrun_fixed", 64'(o_Overrun), 64'd1);
    check_all("t2");

    // 3: memory fills without a halt word; 65th word is ignored
    do_reset();
    start();
    for (int w = 0; w < 65; w++)
      send_word({8'($urandom_range(0, 254)), 24'($urandom)}, 3);
    repeat (8) @(negedge i_clk);
    if (act_q.size() > 0) check("t3.lastaddr", 64'(act_q[$][63:32]), 64'd252);
    check("t3.overflow_fixed", 64'(o_Overflow), 64'd1);
    check_all("t3");

    // 4: asynchronous reset in the middle of word 3
    do_reset();
    start();
    send_word(32'h1234_5678, 3);
    send_word(32'h9ABC_DEF0, 3);
    rx(8'h01, 3); rx(8'h02, 3);
    check_all("t4.pre");
    #2 i_reset = 1'b0;
    #1 check_zero("t4.async");
    m_reset();
    last_wr = -100;
    @(negedge i_clk);
    i_reset = 1'b1;
    @(negedge i_clk);
    start();
    send_word(32'h0BAD_F00D, 3);
    send_word(32'hFFFF_FFFF, 3);
    send_chk(1);
    repeat (8) @(negedge i_clk);
    check_all("t4.post");

    // 5: i_Start ignored mid-load, honoured in DONE
    do_reset();
    start();
    rx(8'hC0, 3); rx(8'hFF, 3);
    start();
    rx(8'hEE, 3); rx(8'h01, 3);
    send_word(32'hFFFF_FFFF, 3);
    send_chk(1);
    repeat (8) @(negedge i_clk);
    check_all("t5.mid");
    start();
    check_all("t5.restart");
    rx(8'h5A, 0);
    send_word(32'h7700_0001, 3);
    send_word(32'hFFFF_FFFF, 3);
    send_chk(1);
    repeat (8) @(negedge i_clk);
    check_all("t5.done");
    // simultaneous start and byte in IDLE: byte must not be packed
    do_reset();
    start_rx(8'h99);
    send_word(32'h0102_0304, 3);
    send_word(32'hFFFF_FFFF, 3);
    send_chk(1);
    repeat (8) @(negedge i_clk);
    check_all("t5.idle_both");

    // randomized streams with random byte spacing
    for (int it = 0; it < 4; it++) begin
      do_reset();
      start();
      for (int j = 0; j < int'($urandom_range(1, 6)) * 4; j++)
        rx(8'($urandom), $urandom_range(0, 4));
      send_word(32'hFFFF_FFFF, 3);
      send_chk(it[0]);
      repeat (8) @(negedge i_clk);
      check_all($sformatf("rnd%0d", it));
    end

`ifdef LOADER_CHECKSUM_EN
    // 6: checksum good and bad
    do_reset();
    start();
    send_word(32'h1020_3040, 3);
    send_word(32'hFFFF_FFFF, 3);
    send_chk(0);
    repeat (8) @(negedge i_clk);
    check("t6.chkerr_fixed", 64'(o_ChkErr), 64'd1);
    check_all("t6.bad");
    start();
    send_word(32'h1020_3040, 3);
    send_word(32'hFFFF_FFFF, 3);
    send_chk(1);
    repeat (8) @(negedge i_clk);
    check("t6.loaded_fixed", 64'(o_Loaded), 64'd1);
    check_all("t6.good");
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
